// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types for the memory-access stage
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE,
    HALTED
  } mem_state_t;

  localparam int WAIT_CNT_W = 16;

  // Cache requests are word granular; drop the byte offset.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - pipeline/cache signal bundle around the memory-access stage
interface mem_access_ctrl_if;
  import cpu_types_pkg::*;

  logic                  dREN_EX_MEM;
  logic                  dWEN_EX_MEM;
  logic                  halt_EX_MEM;
  word_t                 result_EX_MEM;
  word_t                 store_EX_MEM;
  logic                  dhit;
  word_t                 dload;
  logic                  dmemREN;
  logic                  dmemWEN;
  word_t                 dmemaddr;
  word_t                 dmemstore;
  word_t                 dmemload;
  logic                  mem_stall;
  logic                  halt;
  logic [WAIT_CNT_W-1:0] wait_cycles;

  // Pipeline registers and cache drive the requests and responses.
  modport master (
    output dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, result_EX_MEM, store_EX_MEM,
    output dhit, dload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, dmemload, mem_stall, halt, wait_cycles
  );

  // The controller sits between EX/MEM and MEM/WB.
  modport slave (
    input  dREN_EX_MEM, dWEN_EX_MEM, halt_EX_MEM, result_EX_MEM, store_EX_MEM,
    input  dhit, dload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, dmemload, mem_stall, halt, wait_cycles
  );

endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Increment while enabled, sticking at all-ones.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data-memory request sequencer and pipeline stall source
module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  mem_access_ctrl_if.slave  bus
);

  mem_state_t state_q, state_d;
  logic       halt_pend_q, halt_pend_d;
  word_t      load_q, load_d;

  logic       ren, wen, stall, cnt_en;
  logic       op, is_load;

  // A write wins when both enables are set, so a load is read-only.
  assign op      = bus.dREN_EX_MEM | bus.dWEN_EX_MEM;
  assign is_load = bus.dREN_EX_MEM & ~bus.dWEN_EX_MEM;

  // Next state, strobes and stall; everything forced quiet while in reset.
  always_comb begin
    state_d     = state_q;
    halt_pend_d = halt_pend_q;
    load_d      = load_q;
    ren         = 1'b0;
    wen         = 1'b0;
    stall       = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (op) begin
          ren         = is_load;
          wen         = bus.dWEN_EX_MEM;
          stall       = 1'b1;
          halt_pend_d = bus.halt_EX_MEM;
          if (bus.dhit) begin
            state_d = DONE;
            if (is_load) load_d = bus.dload;
          end else begin
            state_d = WAIT;
          end
        end else if (bus.halt_EX_MEM) begin
          state_d = HALTED;
        end
      end
      WAIT: begin
        ren         = is_load;
        wen         = bus.dWEN_EX_MEM;
        stall       = 1'b1;
        halt_pend_d = halt_pend_q | bus.halt_EX_MEM;
        if (bus.dhit) begin
          state_d = DONE;
          if (is_load) load_d = bus.dload;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        // One quiet cycle lets the pipeline advance past the finished op.
        state_d     = halt_pend_q ? HALTED : IDLE;
        halt_pend_d = 1'b0;
      end
      HALTED: begin
        stall = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (!nRST) begin
      ren    = 1'b0;
      wen    = 1'b0;
      stall  = 1'b0;
      cnt_en = 1'b0;
    end
  end

  // State, pending-halt flag and captured load data.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      halt_pend_q <= 1'b0;
      load_q      <= '0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
      load_q      <= load_d;
    end
  end

  sat_counter #(
    .WIDTH (WAIT_CNT_W)
  ) u_wait_cnt (
    .clk_i   (CLK),
    .nrst_i  (nRST),
    .en_i    (cnt_en),
    .count_o (bus.wait_cycles)
  );

  assign bus.dmemREN   = ren;
  assign bus.dmemWEN   = wen;
  assign bus.mem_stall = stall;
  assign bus.halt      = (state_q == HALTED);
  assign bus.dmemaddr  = word_align(bus.result_EX_MEM);
  assign bus.dmemstore = bus.store_EX_MEM;
  assign bus.dmemload  = load_q;

endmodule
